// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } tt_state_e;

    // Number of input vectors for an n-input function
    function automatic int unsigned nvec(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Width of a counter that must hold 0..s
    function automatic int unsigned settle_w(input int unsigned s);
        return (s + 1 <= 1) ? 1 : $clog2(s + 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table characterisation of a 1-bit combinational function.
// Walks every input vector, holds it for SETTLE cycles, samples on the next
// cycle and compares each sample against the EXPECTED table.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned              N_IN     = 4,
    parameter int unsigned              SETTLE   = 1,
    parameter logic [nvec(N_IN)-1:0]    EXPECTED = 16'h0FF0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    dut_out,
    output logic [N_IN-1:0]         dut_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic                    fail_valid,
    output logic [N_IN-1:0]         first_fail,
    output logic [nvec(N_IN)-1:0]   captured
);

    localparam int unsigned         NVEC     = nvec(N_IN);
    localparam int unsigned         SW       = settle_w(SETTLE);
    // Vector counter is one bit wider than dut_in so the last-vector compare cannot wrap
    localparam logic [N_IN:0]       VEC_LAST = (N_IN+1)'(NVEC - 1);
    localparam logic [N_IN:0]       VEC_ONE  = (N_IN+1)'(1);
    localparam logic [SW-1:0]       CNT_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0]       CNT_ONE  = SW'(1);

    tt_state_e          state_q, state_d;
    logic [N_IN:0]      vec_q, vec_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [N_IN-1:0]    dut_in_q, dut_in_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [N_IN:0]      err_q, err_d;
    logic               fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]    first_fail_q, first_fail_d;
    logic [NVEC-1:0]    captured_q, captured_d;
    logic [N_IN-1:0]    vec_idx;
    logic               mismatch;

    assign vec_idx  = vec_q[N_IN-1:0];
    assign mismatch = (dut_out != EXPECTED[vec_idx]);

    // Next-state and datapath updates for the sweep FSM
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        dut_in_d     = dut_in_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        captured_d   = captured_q;

        unique case (state_q)
            StIdle: begin
                dut_in_d = '0;
                if (start) begin
                    vec_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    captured_d   = '0;
                    pass_d       = 1'b0;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StSample: begin
                captured_d[vec_idx] = dut_out;
                if (mismatch) begin
                    err_d = err_q + VEC_ONE;
                    if (!fail_valid_q) begin
                        first_fail_d = vec_idx;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = StDone;
                end else begin
                    vec_d    = vec_q + VEC_ONE;
                    dut_in_d = vec_d[N_IN-1:0];
                    state_d  = StSettle;
                end
            end
            StDone: begin
                done_d   = 1'b1;
                pass_d   = (err_q == '0);
                dut_in_d = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            cnt_q        <= '0;
            dut_in_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            captured_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            dut_in_q     <= dut_in_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            captured_q   <= captured_d;
        end
    end

    assign busy       = (state_q == StSettle) || (state_q == StSample);
    assign dut_in     = dut_in_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;
    assign captured   = captured_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: four sweeper instances with different functions and tables.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_v;
    logic [3:0] done_v;

    int tests = 0;
    int fails = 0;

    // u1: N_IN=2, f=A|(A&B), table matches
    logic [1:0] dut_in1;
    logic       dut_out1, busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] ff1;
    logic [3:0] cap1;
    // u2: same function, wrong table
    logic [1:0] dut_in2;
    logic       dut_out2, busy2, done2, pass2, fv2;
    logic [2:0] err2;
    logic [1:0] ff2;
    logic [3:0] cap2;
    // u3: N_IN=4, SETTLE=3, f=C xor D
    logic [3:0]  dut_in3;
    logic        dut_out3, busy3, done3, pass3, fv3;
    logic [4:0]  err3;
    logic [3:0]  ff3;
    logic [15:0] cap3;
    // u4: output tied high
    logic [1:0] dut_in4;
    logic       busy4, done4, pass4, fv4;
    logic [2:0] err4;
    logic [1:0] ff4;
    logic [3:0] cap4;

    assign dut_out1 = dut_in1[0] | (dut_in1[0] & dut_in1[1]);
    assign dut_out2 = dut_in2[0] | (dut_in2[0] & dut_in2[1]);
    assign dut_out3 = (dut_in3[2] & ~dut_in3[3]) | (dut_in3[3] & ~dut_in3[2]);
    assign done_v   = {done4, done3, done2, done1};

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b1010)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_out(dut_out1), .dut_in(dut_in1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
        .first_fail(ff1), .captured(cap1)
    );
    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b1011)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_out(dut_out2), .dut_in(dut_in2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2),
        .first_fail(ff2), .captured(cap2)
    );
    truth_table_sweeper #(.N_IN(4), .SETTLE(3), .EXPECTED(16'h0FF0)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_out(dut_out3), .dut_in(dut_in3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3),
        .first_fail(ff3), .captured(cap3)
    );
    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b1010)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_out(1'b1), .dut_in(dut_in4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_valid(fv4),
        .first_fail(ff4), .captured(cap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one rising edge; returns #1 after that edge (t0)
    task automatic pulse_start(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    // Count edges after t0 until done is seen; n0 edges already elapsed
    task automatic wait_done(input int k, input int n0, input int exp_lat, input string tag);
        int  n;
        bit  seen;
        n    = n0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done_v[k] === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? n : -1, exp_lat);
    endtask

    task automatic check_u1_ok(input string tag);
        check({tag, "_pass"}, 32'(pass1), 32'd1);
        check({tag, "_err"}, 32'(err1), 32'd0);
        check({tag, "_fv"}, 32'(fv1), 32'd0);
        check({tag, "_ff"}, 32'(ff1), 32'd0);
        check({tag, "_cap"}, 32'(cap1), 32'hA);
    endtask

    initial begin
        int n;
        int bad;
        int pulses;

        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy", {busy4, busy3, busy2, busy1}, 32'd0);
        check("rst_done", 32'(done_v), 32'd0);
        check("rst_pass", {pass4, pass3, pass2, pass1}, 32'd0);
        check("rst_err", {err4, err3, err2, err1}, 32'd0);
        check("rst_dut_in", {dut_in4, dut_in3, dut_in2, dut_in1}, 32'd0);
        check("rst_cap", {cap4, cap3, cap2, cap1}, 32'd0);
        check("rst_fail", {fv4, fv3, fv2, fv1, ff4, ff3, ff2, ff1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: matching table
        pulse_start(0);
        check("t1_busy_after_start", 32'(busy1), 32'd1);
        check("t1_dut_in_v0", 32'(dut_in1), 32'd0);
        wait_done(0, 0, 9, "t1");
        check("t1_busy_at_done", 32'(busy1), 32'd0);
        check_u1_ok("t1");
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", 32'(done1), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_pass_held", 32'(pass1), 32'd1);

        // Test 2: table differs at vector 0
        pulse_start(1);
        wait_done(1, 0, 9, "t2");
        check("t2_pass", 32'(pass2), 32'd0);
        check("t2_err", 32'(err2), 32'd1);
        check("t2_ff", 32'(ff2), 32'd0);
        check("t2_fv", 32'(fv2), 32'd1);
        check("t2_cap", 32'(cap2), 32'hA);

        // Test 3: 4-input XOR of C,D with a 3-cycle settle
        pulse_start(2);
        check("t3_dut_in_v0", 32'(dut_in3), 32'd0);
        n   = 0;
        bad = 0;
        while (n < 300 && done3 !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 64 && dut_in3 !== 4'(n >> 2)) bad++;
        end
        check("t3_latency", (done3 === 1'b1) ? n : -1, 32'd65);
        check("t3_dut_in_steps_bad", bad, 32'd0);
        check("t3_pass", 32'(pass3), 32'd1);
        check("t3_err", 32'(err3), 32'd0);
        check("t3_cap", 32'(cap3), 32'h0FF0);

        // Test 4: stuck-at-1 output
        pulse_start(3);
        wait_done(3, 0, 9, "t4");
        check("t4_err", 32'(err4), 32'd2);
        check("t4_ff", 32'(ff4), 32'd0);
        check("t4_fv", 32'(fv4), 32'd1);
        check("t4_pass", 32'(pass4), 32'd0);
        check("t4_cap", 32'(cap4), 32'hF);

        // Test 5: start pulsed again while sweeping vector 1
        pulse_start(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_dut_in_v1", 32'(dut_in1), 32'd1);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 3, 9, "t5");
        check_u1_ok("t5");
        pulses = 0;
        bad    = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1) pulses++;
            if (busy1 !== 1'b0) bad++;
        end
        check("t5_extra_done", pulses, 32'd0);
        check("t5_no_restart", bad, 32'd0);

        // Test 6: asynchronous reset mid-sweep, then a clean sweep
        pulse_start(0);
        n = 0;
        while (n < 40 && dut_in1 !== 2'd2) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_reach_v2", 32'(dut_in1), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy1), 32'd0);
        check("t6_rst_dut_in", 32'(dut_in1), 32'd0);
        check("t6_rst_results", {done1, pass1, fv1, err1, ff1, cap1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        check("t6_dut_in_v0", 32'(dut_in1), 32'd0);
        wait_done(0, 0, 9, "t6");
        check_u1_ok("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
